// File: rtl/uart_tx_feeder.sv
// Character FIFO that feeds a UART transmitter one frame at a time.
// Optional sticky overflow flag is enabled by defining UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder #(
  parameter int CLKS_PER_BIT = 521,
  parameter int FRAME_BITS   = 10,
  parameter int DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [6:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     tx_start,
  output logic [6:0]               datain_tx,
  output logic                     tx_busy,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW           = $clog2(DEPTH);
  localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
  localparam int CW           = $clog2(FRAME_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t        state, state_next;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] frame_cnt;
  logic          push, pop, frame_done;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  // full is the pre-edge value, so a write that meets a pop while full is still dropped
  assign push       = wr_en & ~full;
  assign pop        = (state == IDLE) & ~empty;
  assign frame_done = (frame_cnt == CW'(FRAME_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      datain_tx <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        datain_tx <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == START)     frame_cnt <= '0;
      else if (state == WAIT) frame_cnt <= frame_cnt + CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    tx_busy    = 1'b0;
    case (state)
      IDLE:  if (pop) state_next = START;
      START: begin
        tx_start   = 1'b1;
        tx_busy    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        tx_busy = 1'b1;
        if (frame_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_TX_FEEDER_OVF_EN
  // A drop wins over a clear on the same edge so no overflow event is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ovf <= 1'b0;
    else if (wr_en && full)   ovf <= 1'b1;
    else if (ovf_clr)         ovf <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder at default parameters.
// Expected ovf behaviour follows whether UART_TX_FEEDER_OVF_EN is defined.
module tb_uart_tx_feeder;

  localparam int GAP  = 5212;
  localparam int BUSY = 5211;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, ovf_clr;
  logic [6:0] wr_data;
  logic       full, empty, tx_start, tx_busy, ovf;
  logic [3:0] count;
  logic [6:0] datain_tx;

  int errors = 0;
  int checks = 0;

`ifdef UART_TX_FEEDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  uart_tx_feeder dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .tx_start(tx_start),
    .datain_tx(datain_tx), .tx_busy(tx_busy), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
    #23;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    checks++; if (tx_start !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx got start=%b busy=%b exp 0/0", tx_start, tx_busy); end
    checks++; if (datain_tx !== 7'h00 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_data got data=%h ovf=%b exp 00/0", datain_tx, ovf); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    int busy_cycles, pulses;
    wr_en = 1'b1; wr_data = 7'h5B;
    tick();
    wr_en = 1'b0;
    checks++; if (count !== 4'd1 || tx_start !== 1'b0) begin errors++; $display("[TB] FAIL single_queued got count=%0d start=%b exp 1/0", count, tx_start); end
    tick();
    checks++; if (tx_start !== 1'b1 || datain_tx !== 7'h5B) begin errors++; $display("[TB] FAIL single_launch got start=%b data=%h exp 1/5b", tx_start, datain_tx); end
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL single_pop got count=%0d empty=%b exp 0/1", count, empty); end
    busy_cycles = 1; pulses = 0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (tx_start) pulses++;
      if (!tx_busy) break;
      busy_cycles++;
    end
    checks++; if (busy_cycles != BUSY) begin errors++; $display("[TB] FAIL single_busy got=%0d exp=%0d", busy_cycles, BUSY); end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL single_extra_pulse got=%0d exp=0", pulses); end
    checks++; if (empty !== 1'b1 || datain_tx !== 7'h5B) begin errors++; $display("[TB] FAIL single_after got empty=%b data=%h exp 1/5b", empty, datain_tx); end
  endtask

  task automatic test_back_to_back();
    int gap, pulses;
    bit seen;
    wr_en = 1'b1; wr_data = 7'h5B;
    tick();
    wr_data = 7'h71;
    tick();
    wr_en = 1'b0;
    checks++; if (tx_start !== 1'b1 || datain_tx !== 7'h5B) begin errors++; $display("[TB] FAIL b2b_first got start=%b data=%h exp 1/5b", tx_start, datain_tx); end
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL b2b_push_pop_count got=%0d exp=1", count); end
    gap = 0; seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      gap++;
      if (tx_start) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || gap != GAP) begin errors++; $display("[TB] FAIL b2b_gap got=%0d seen=%b exp=%0d", gap, seen, GAP); end
    checks++; if (datain_tx !== 7'h71) begin errors++; $display("[TB] FAIL b2b_second got=%h exp=71", datain_tx); end
    pulses = 0;
    for (int i = 0; i < 5300; i++) begin
      tick();
      if (tx_start) pulses++;
    end
    checks++; if (pulses != 0 || tx_busy !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tail got pulses=%0d busy=%b empty=%b exp 0/0/1", pulses, tx_busy, empty); end
  endtask

  task automatic test_overflow();
    int pulses;
    bit seen;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 7'(i);
      tick();
      if (i == 1) begin
        checks++; if (tx_start !== 1'b1 || datain_tx !== 7'h00) begin errors++; $display("[TB] FAIL ovf_first_pop got start=%b data=%h exp 1/00", tx_start, datain_tx); end
      end
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("[TB] FAIL ovf_full got full=%b count=%0d exp 1/8", full, count); end
    checks++; if (ovf !== OVF_ON) begin errors++; $display("[TB] FAIL ovf_set got=%b exp=%b", ovf, OVF_ON); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got=%b exp=0", ovf); end
    wr_en = 1'b1; wr_data = 7'h55; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    checks++; if (ovf !== OVF_ON || count !== 4'd8) begin errors++; $display("[TB] FAIL ovf_clr_vs_drop got ovf=%b count=%0d exp %b/8", ovf, count, OVF_ON); end
    // Keep writing while full until the next pop; the coincident write must be dropped
    wr_en = 1'b1; wr_data = 7'h7F; seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (tx_start) begin seen = 1'b1; break; end
    end
    wr_en = 1'b0;
    checks++; if (!seen || count !== 4'd7 || full !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_drop got seen=%b count=%0d full=%b exp 1/7/0", seen, count, full); end
    checks++; if (datain_tx !== 7'h01) begin errors++; $display("[TB] FAIL ovf_frame1 got=%h exp=01", datain_tx); end
    for (int k = 2; k <= 8; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 5300; i++) begin
        tick();
        if (tx_start) begin seen = 1'b1; break; end
      end
      checks++; if (!seen || datain_tx !== 7'(k)) begin errors++; $display("[TB] FAIL ovf_frame%0d got seen=%b data=%h exp 1/%h", k, seen, datain_tx, 7'(k)); end
    end
    pulses = 0;
    for (int i = 0; i < 5300; i++) begin
      tick();
      if (tx_start) pulses++;
    end
    checks++; if (pulses != 0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL ovf_tail got pulses=%0d empty=%b exp 0/1", pulses, empty); end
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 7'(8'h20 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    checks++; if (count !== 4'd3 || tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre got count=%0d busy=%b exp 3/1", count, tx_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_fifo got count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); end
    checks++; if (tx_busy !== 1'b0 || tx_start !== 1'b0 || datain_tx !== 7'h00 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_tx got busy=%b start=%b data=%h ovf=%b exp 0/0/00/0", tx_busy, tx_start, datain_tx, ovf); end
    tick();
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (tx_start) pulses++;
    end
    checks++; if (pulses != 0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_after got pulses=%0d empty=%b exp 0/1", pulses, empty); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
